rx_stream_arbiter: RTL

Round-robin arbiter that shares one AXI-Stream master port between NUM_CH serial-receiver word streams, one per LVDS receive lane.
- Grants one channel at a time for a fixed burst of BURST_LEN words.
- Asserts tlast on the final word of each burst and tags each word with its source channel.
- Sits between the per-lane receiver outputs and the DMA-facing AXI-Stream port.

---
 rtl/rx_stream_arbiter_if.sv | 28 ++
 rtl/rx_stream_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rx_stream_arbiter_if.sv
// Stream bundle between the per-lane receivers and the DMA-facing port.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface rx_stream_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_CH-1:0]            s_tvalid;
    logic [NUM_CH-1:0]            s_tready;
    logic [DATA_WIDTH-1:0]        m_tdata;
    logic                         m_tvalid;
    logic                         m_tready;
    logic                         m_tlast;
    logic [CH_W-1:0]              m_tuser;
    logic [DATA_WIDTH/8-1:0]      m_tstrb;

    modport master (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast, m_tuser, m_tstrb
    );

    modport slave (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast, m_tuser, m_tstrb
    );
endinterface

// File: rtl/rx_stream_arbiter.sv
// Round-robin burst arbiter: grants one receiver lane at a time for BURST_LEN
// words, tags each word with its lane and marks the burst end with tlast.
module rx_stream_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [NUM_CH-1:0]       ch_enable,
    rx_stream_arbiter_if.master     strm,
    output logic [15:0]             burst_cnt,
    output logic                    busy
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(BURST_LEN);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]            state;
    logic [CH_W-1:0]       grant;
    logic [CH_W-1:0]       last_grant;
    logic [CNT_W-1:0]      wcnt;

    logic [NUM_CH-1:0]     req;
    logic [CH_W:0]         pick;
    logic [NUM_CH-1:0]     ready;
    logic                  accept;
    logic                  last_word;
    logic [DATA_WIDTH-1:0] grant_data;

    logic [DATA_WIDTH-1:0] data_p0;
    logic [CH_W-1:0]       user_p0;
    logic                  last_p0;
    logic                  vld_p0;

    // Returns {found, index}; walking k downward lets the nearest requester after
    // last win without an early exit from the loop.
    function automatic logic [CH_W:0] rr_pick(
        input logic [NUM_CH-1:0] r,
        input logic [CH_W-1:0]   last
    );
        logic [CH_W:0]   res;
        logic [CH_W-1:0] sel;
        int              idx;
        res = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_CH;
            sel = CH_W'(idx);
            if (r[sel]) begin
                res = {1'b1, sel};
            end
        end
        return res;
    endfunction

    assign req        = strm.s_tvalid & ch_enable;
    assign pick       = rr_pick(req, last_grant);
    assign grant_data = strm.s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign last_word  = (wcnt == CNT_W'(BURST_LEN - 1));

    always_comb begin
        ready = '0;
        if (state == BURST) begin
            ready[grant] = ~vld_p0 | strm.m_tready;
        end
    end

    assign accept = |(ready & strm.s_tvalid);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            wcnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick[CH_W]) begin
                        state <= BURST;
                        grant <= pick[CH_W-1:0];
                        wcnt  <= '0;
                    end
                end
                default: begin
                    if (accept) begin
                        if (last_word) begin
                            state      <= IDLE;
                            last_grant <= grant;
                            wcnt       <= '0;
                        end else begin
                            wcnt <= wcnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // ---- stage p0: output register, holds its word while downstream stalls ----
    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            user_p0 <= '0;
            last_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            data_p0 <= grant_data;
            user_p0 <= grant;
            last_p0 <= last_word;
        end else if (vld_p0 && strm.m_tready) begin
            vld_p0 <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            burst_cnt <= '0;
        end else if (vld_p0 && strm.m_tready && last_p0) begin
            burst_cnt <= burst_cnt + 16'd1;
        end
    end

    assign strm.s_tready = ready;
    assign strm.m_tdata  = data_p0;
    assign strm.m_tvalid = vld_p0;
    assign strm.m_tlast  = last_p0;
    assign strm.m_tuser  = user_p0;
    assign strm.m_tstrb  = '1;
    assign busy          = (state == BURST);
endmodule
